// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA decryption engine: FSM states,
// default operand width and the octet-string byte-reversal function.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SQR  = 3'd2,
    MUL  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int DEFAULT_W = 256;
  localparam int MAX_W     = 2048;

  // Reverses the low nbytes octets of x; bits above 8*nbytes come back as zero.
  function automatic logic [MAX_W-1:0] byte_rev(input logic [MAX_W-1:0] x, input int nbytes);
    logic [MAX_W-1:0] y;
    y = {MAX_W{1'b0}};
    for (int k = 0; k < MAX_W / 8; k++) begin
      if (k < nbytes) begin
        y[8*k +: 8] = x[8*(nbytes-1-k) +: 8];
      end else begin
        y[8*k +: 8] = 8'h00;
      end
    end
    return y;
  endfunction

endpackage

// File: rtl/rsa_modmul.sv
// Bit-serial Blakley modular multiplier: a*b mod n in W cycles, one bit of a per cycle.
// o_done/o_p flag the final iteration combinationally so the caller can capture on that edge.
module rsa_modmul #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_n,
  output logic         o_done,
  output logic [W-1:0] o_p
);

  localparam int JW = $clog2(W);

  logic [W+1:0]  r_p;
  logic [JW-1:0] r_j;
  logic          r_active;

  logic [W+1:0]  w_p_in;
  logic [W+1:0]  w_n_ext;
  logic [W+1:0]  w_acc;
  logic [W+1:0]  w_sub1;
  logic [W+1:0]  w_sub2;
  logic          w_bit;

  // One Blakley step: 2P + a[j]*b is below 3n, so two conditional subtractions reduce it.
  always_comb begin
    w_p_in  = i_start ? {(W+2){1'b0}} : r_p;
    w_bit   = i_start ? i_a[W-1] : i_a[r_j];
    w_n_ext = {2'b00, i_n};
    w_acc   = (w_p_in << 1) + (w_bit ? {2'b00, i_b} : {(W+2){1'b0}});
    w_sub1  = (w_acc >= w_n_ext) ? (w_acc - w_n_ext) : w_acc;
    w_sub2  = (w_sub1 >= w_n_ext) ? (w_sub1 - w_n_ext) : w_sub1;
    o_done  = r_active && (r_j == {JW{1'b0}});
    o_p     = w_sub2[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p      <= {(W+2){1'b0}};
      r_j      <= {JW{1'b0}};
      r_active <= 1'b0;
    end else if (i_start) begin
      r_p      <= w_sub2;
      r_j      <= JW'(W - 2);
      r_active <= 1'b1;
    end else if (r_active) begin
      r_p <= w_sub2;
      if (r_j == {JW{1'b0}}) begin
        r_active <= 1'b0;
      end else begin
        r_j <= r_j - {{(JW-1){1'b0}}, 1'b1};
      end
    end else begin
      r_p <= r_p;
    end
  end

endmodule

// File: rtl/rsa_decrypt_engine.sv
// RSA decryption core m = c^d mod n by constant-time left-to-right square-and-multiply.
// Define RSA_OS_CONV_EN to byte-reverse c on capture and m on output (W must be a multiple of 8).
module rsa_decrypt_engine
  import rsa_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int EXP_W = W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] d,
  input  logic [W-1:0]     n,
  input  logic [W-1:0]     c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     m,
  output logic             err,
  output logic             busy
);

  localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  state_e           r_state;
  logic [EXP_W-1:0] r_d;
  logic [W-1:0]     r_n;
  logic [W-1:0]     r_c;
  logic [W-1:0]     r_r;
  logic [IW-1:0]    r_idx;
  logic             r_start;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [W-1:0]     r_m;
  logic             r_err;
  logic             r_busy;

  logic             w_mm_done;
  logic [W-1:0]     w_mm_p;
  logic [W-1:0]     w_mm_b;
  logic [W-1:0]     w_r_final;
  logic [W-1:0]     w_c_in;
  logic [W-1:0]     w_m_out;

`ifdef RSA_OS_CONV_EN
  if ((W % 8) != 0) begin : g_bad_width
    $error("rsa_decrypt_engine: W must be a multiple of 8 when RSA_OS_CONV_EN is defined");
  end
  logic [MAX_W-1:0] w_c_rev;
  logic [MAX_W-1:0] w_m_rev;
  assign w_c_rev = byte_rev(MAX_W'(c), W / 8);
  assign w_m_rev = byte_rev(MAX_W'(w_r_final), W / 8);
  assign w_c_in  = w_c_rev[W-1:0];
  assign w_m_out = w_m_rev[W-1:0];
`else
  assign w_c_in  = c;
  assign w_m_out = w_r_final;
`endif

  // Multiply result is discarded for zero exponent bits so every bit costs the same time.
  assign w_mm_b    = (r_state == MUL) ? r_c : r_r;
  assign w_r_final = r_d[r_idx] ? w_mm_p : r_r;

  rsa_modmul #(.W(W)) u_modmul (
    .clk     (clk),
    .reset   (reset),
    .i_start (r_start),
    .i_a     (r_r),
    .i_b     (w_mm_b),
    .i_n     (r_n),
    .o_done  (w_mm_done),
    .o_p     (w_mm_p)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_d         <= {EXP_W{1'b0}};
      r_n         <= {W{1'b0}};
      r_c         <= {W{1'b0}};
      r_r         <= {W{1'b0}};
      r_idx       <= {IW{1'b0}};
      r_start     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_m         <= {W{1'b0}};
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_d        <= d;
            r_n        <= n;
            r_c        <= w_c_in;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= LOAD;
          end else begin
            r_state <= IDLE;
          end
        end
        LOAD: begin
          if ((r_n < W'(2)) || (r_c >= r_n)) begin
            r_err   <= 1'b1;
            r_m     <= {W{1'b0}};
            r_busy  <= 1'b0;
            r_state <= DONE;
          end else begin
            r_r     <= W'(1);
            r_idx   <= IW'(EXP_W - 1);
            r_start <= 1'b1;
            r_state <= SQR;
          end
        end
        SQR: begin
          r_start <= 1'b0;
          if (w_mm_done) begin
            r_r     <= w_mm_p;
            r_start <= 1'b1;
            r_state <= MUL;
          end else begin
            r_state <= SQR;
          end
        end
        MUL: begin
          r_start <= 1'b0;
          if (w_mm_done) begin
            r_r <= w_r_final;
            if (r_idx == {IW{1'b0}}) begin
              r_m     <= w_m_out;
              r_err   <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= DONE;
            end else begin
              r_idx   <= r_idx - {{(IW-1){1'b0}}, 1'b1};
              r_start <= 1'b1;
              r_state <= SQR;
            end
          end else begin
            r_state <= MUL;
          end
        end
        DONE: begin
          // Result is presented one cycle after entering DONE and held until taken.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_m         <= {W{1'b0}};
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_state <= DONE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_start    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign m         = r_m;
  assign err       = r_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_rsa_decrypt_engine.sv
// Directed bench for rsa_decrypt_engine: an 8-bit instance for functional/handshake cases
// and a second wider instance (12-bit, or 16-bit octet-string mode under RSA_OS_CONV_EN).
module tb_rsa_decrypt_engine;

`ifdef RSA_OS_CONV_EN
  localparam int W2 = 16;
  localparam int E2 = 8;
`else
  localparam int W2 = 12;
  localparam int E2 = 12;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, err8, busy8;
  logic [7:0] d8, n8, c8, m8;

  logic          in_valid2, in_ready2, out_valid2, out_ready2, err2, busy2;
  logic [E2-1:0] d2;
  logic [W2-1:0] n2, c2, m2;

  rsa_decrypt_engine #(.W(8), .EXP_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .d(d8), .n(n8), .c(c8), .out_valid(out_valid8), .out_ready(out_ready8),
    .m(m8), .err(err8), .busy(busy8)
  );

  rsa_decrypt_engine #(.W(W2), .EXP_W(E2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .d(d2), .n(n2), .c(c2), .out_valid(out_valid2), .out_ready(out_ready2),
    .m(m2), .err(err2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issues one job on the 8-bit DUT from a negedge and returns at the negedge where out_valid is first seen.
  task automatic run8(input logic [7:0] d_i, input logic [7:0] n_i, input logic [7:0] c_i,
                      output logic [7:0] m_o, output logic err_o, output int lat_o, output logic to_o);
    int t0;
    int k;
    k = 0;
    while (!in_ready8 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    d8 = d_i; n8 = n_i; c8 = c_i;
    in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    in_valid8 = 1'b0;
    k = 0;
    while (k < 2000) begin
      @(negedge clk);
      k++;
      if (out_valid8) break;
    end
    to_o  = !out_valid8;
    m_o   = m8;
    err_o = err8;
    lat_o = cyc - t0;
  endtask

  initial begin
    logic [7:0]    m_s;
    logic          e_s;
    int            lat_s;
    logic          to_s;
    logic          held_ok;
    logic          never_ok;
    logic [W2-1:0] exp_m2;
    int            exp_lat2;
    int            t0;
    int            k;

    in_valid8 = 1'b0; out_ready8 = 1'b1; d8 = 8'd0; n8 = 8'd0; c8 = 8'd0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; d2 = '0; n2 = '0; c2 = '0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready8), 32'd1);
    check("rst_out_valid", 32'(out_valid8), 32'd0);
    check("rst_m", 32'(m8), 32'd0);
    check("rst_err", 32'(err8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 31^7 mod 33 = 4, latency 2 + 2*8*8
    run8(8'd7, 8'd33, 8'd31, m_s, e_s, lat_s, to_s);
    check("A_timeout", 32'(to_s), 32'd0);
    check("A_m", 32'(m_s), 32'd4);
    check("A_err", 32'(e_s), 32'd0);
    check("A_lat", 32'(lat_s), 32'd130);
    @(posedge clk); @(negedge clk);
    check("A_in_ready_after", 32'(in_ready8), 32'd1);
    check("A_out_valid_after", 32'(out_valid8), 32'd0);

    run8(8'd7, 8'd33, 8'd40, m_s, e_s, lat_s, to_s);
    check("range_err", 32'(e_s), 32'd1);
    check("range_m", 32'(m_s), 32'd0);
    check("range_lat", 32'(lat_s), 32'd2);
    @(posedge clk); @(negedge clk);

    run8(8'd7, 8'd1, 8'd0, m_s, e_s, lat_s, to_s);
    check("n1_err", 32'(e_s), 32'd1);
    check("n1_lat", 32'(lat_s), 32'd2);
    @(posedge clk); @(negedge clk);

    run8(8'd0, 8'd33, 8'd5, m_s, e_s, lat_s, to_s);
    check("d0_m", 32'(m_s), 32'd1);
    check("d0_err", 32'(e_s), 32'd0);
    check("d0_lat", 32'(lat_s), 32'd130);
    @(posedge clk); @(negedge clk);

    run8(8'd7, 8'd33, 8'd0, m_s, e_s, lat_s, to_s);
    check("c0_m", 32'(m_s), 32'd0);
    check("c0_err", 32'(e_s), 32'd0);
    @(posedge clk); @(negedge clk);

    // Back-pressure: 4^3 mod 33 = 31 held for 20 cycles while a new job is offered
    out_ready8 = 1'b0;
    run8(8'd3, 8'd33, 8'd4, m_s, e_s, lat_s, to_s);
    check("bp_m", 32'(m_s), 32'd31);
    held_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid8 = 1'b1; d8 = 8'd5; n8 = 8'd33; c8 = 8'd2;
      @(negedge clk);
      if (!(out_valid8 === 1'b1 && in_ready8 === 1'b0 && m8 === 8'd31 && err8 === 1'b0)) held_ok = 1'b0;
    end
    check("bp_held", 32'(held_ok), 32'd1);
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp_in_ready", 32'(in_ready8), 32'd1);
    check("bp_out_valid", 32'(out_valid8), 32'd0);
    run8(8'd7, 8'd33, 8'd31, m_s, e_s, lat_s, to_s);
    check("bp_next_m", 32'(m_s), 32'd4);
    check("bp_next_lat", 32'(lat_s), 32'd130);
    @(posedge clk); @(negedge clk);

    // Reset during squaring aborts the job
    d8 = 8'd7; n8 = 8'd33; c8 = 8'd31;
    in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", 32'(busy8), 32'd1);
    check("mid_in_ready", 32'(in_ready8), 32'd0);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", 32'(in_ready8), 32'd1);
    check("abort_busy", 32'(busy8), 32'd0);
    never_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid8 !== 1'b0) never_ok = 1'b0;
    end
    check("abort_no_out", 32'(never_ok), 32'd1);
    run8(8'd3, 8'd33, 8'd4, m_s, e_s, lat_s, to_s);
    check("post_abort_m", 32'(m_s), 32'd31);
    check("post_abort_lat", 32'(lat_s), 32'd130);
    @(posedge clk); @(negedge clk);

`ifdef RSA_OS_CONV_EN
    d2 = 8'd7; n2 = 16'h0021; c2 = 16'h1F00;
    exp_m2 = 16'h0400;
    exp_lat2 = 258;
`else
    d2 = 12'd2753; n2 = 12'd3233; c2 = 12'd2790;
    exp_m2 = 12'd65;
    exp_lat2 = 290;
`endif
    check("w2_in_ready", 32'(in_ready2), 32'd1);
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    in_valid2 = 1'b0;
    k = 0;
    while (k < 5000) begin
      @(negedge clk);
      k++;
      if (out_valid2) break;
    end
    check("w2_timeout", 32'(!out_valid2), 32'd0);
    check("w2_m", 32'(m2), 32'(exp_m2));
    check("w2_err", 32'(err2), 32'd0);
    check("w2_lat", 32'(cyc - t0), 32'(exp_lat2));
    @(posedge clk); @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
